// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule generator.
// Takes one 512-bit block as 16 serial 32-bit words. It then streams the
// schedule words W0..W[ROUNDS-1] over a valid/ready interface.
// The block is built around a 16-word shift window. The recurrence term nxt
// is always W[cnt+16], because the head of the window w[0] holds W[cnt].
module sha256_msg_sched #(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_last,
  output logic        busy
);

  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;
  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  logic [0:0]        state;
  logic [5:0]        cnt;
  logic [15:0][31:0] w;
  logic [31:0]       nxt;
  logic              in_fire;
  logic              out_fire;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    sig0 = ((x >> 7)  | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    sig1 = ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  // The next schedule word is computed from window taps.
  // The sum is taken mod 2^32, so carries out of bit 31 are dropped.
  assign nxt = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == EMIT);
  assign busy      = (state == EMIT);
  assign out_last  = (state == EMIT) && (cnt == LAST);
  assign out_word  = w[0];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Load the window serially, then shift the recurrence through it while emitting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt   <= '0;
      w     <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            w <= {in_word, w[15:1]};
            if (cnt == 6'd15) begin
              cnt   <= '0;
              state <= EMIT;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        default: begin
          if (out_fire) begin
            w <= {nxt, w[15:1]};
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= LOAD;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Randomized self-checking bench for sha256_msg_sched.
// The reference model expands each block with the textbook W[t] recurrence.
// A negedge monitor checks every output handshake against a queue of expected words.
module tb_sha256_msg_sched;
  localparam int ROUNDS = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_word;
  logic        out_last;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;        // 0: always ready, 1: random backpressure
  int blk_idx = 0;         // handshakes seen within the current block
  logic [31:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [31:0] held = '0;

  sha256_msg_sched #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  typedef logic [31:0] blk_t[16];
  typedef logic [31:0] sched_t[64];

  function automatic sched_t expand(input blk_t m);
    sched_t W;
    for (int t = 0; t < 64; t++)
      W[t] = (t < 16) ? m[t] : s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16];
    return W;
  endfunction

  // Random backpressure, changed away from the sampling edge.
  always @(posedge clk) begin
    #1;
    out_ready = (rdy_mode == 0) ? 1'b1 : 1'(($urandom % 3) != 0);
  end

  // Every output handshake must match the next expected word.
  // A stalled word must hold steady.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_vs_valid", {31'b0, in_ready}, {31'b0, ~out_valid});
      if (out_valid) check("busy", {31'b0, busy}, 32'd1);
      if (out_valid && stall_prev) check("stall_hold", out_word, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", out_word, 32'hxxxxxxxx);
        end else begin
          check($sformatf("W%0d", blk_idx), out_word, exp_q.pop_front());
          check("out_last", {31'b0, out_last}, {31'b0, blk_idx == ROUNDS - 1});
          blk_idx = (blk_idx == ROUNDS - 1) ? 0 : blk_idx + 1;
        end
      end else if (!out_valid) begin
        check("out_last_idle", {31'b0, out_last}, 32'd0);
      end
      stall_prev = out_valid && !out_ready;
      held = out_word;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Send one block. A gap inserts idle cycles after word 7. With garbage set,
  // a junk word is presented while waiting for in_ready. With hold set,
  // in_valid stays high afterwards.
  task automatic push_block(input blk_t m, input int gap, input bit garbage, input bit hold);
    sched_t W;
    int n;
    W = expand(m);
    for (int t = 0; t < ROUNDS; t++) exp_q.push_back(W[t]);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_word  = garbage ? 32'hDEADBEEF : m[i];
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        $display("FAIL in_ready_timeout: got 0 expected 1");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
      end
      in_word = m[i];
      @(posedge clk);
      #1;
      if (i == 7 && gap > 0) begin
        in_valid = 1'b0;
        in_word  = 32'h0BADF00D;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    in_valid = hold;
    in_word  = 32'hDEADBEEF;
    @(negedge clk);
    check("first_valid_latency", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("drain_remaining", exp_q.size(), 0);
  endtask

  task automatic rand_block(output blk_t m);
    for (int i = 0; i < 16; i++) m[i] = $urandom;
  endtask

  initial begin
    blk_t abc, zero, ones, r;
    sched_t W;
    int n;
    for (int i = 0; i < 16; i++) begin
      abc[i] = '0; zero[i] = '0; ones[i] = 32'hFFFFFFFF;
    end
    abc[0] = 32'h61626380;
    abc[15] = 32'h00000018;

    // Pin the model with hand-computed values.
    W = expand(abc);
    check("model_abc_W16", W[16], 32'h61626380);
    check("model_abc_W17", W[17], 32'h000F0000);
    W = expand(ones);
    check("model_ff_W16", W[16], 32'h203FFFFC);

    // Reset state.
    #12;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_last", {31'b0, out_last}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_out_word", out_word, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // abc block at full rate.
    push_block(abc, 0, 1'b0, 1'b0);
    drain();

    // abc again under backpressure.
    rdy_mode = 1;
    push_block(abc, 0, 1'b0, 1'b0);
    drain();

    // Input gap of 3 cycles between words 7 and 8.
    rand_block(r);
    push_block(r, 3, 1'b0, 1'b0);
    drain();

    // Reset mid-EMIT at t = 30, then an all-zero block.
    rdy_mode = 0;
    rand_block(r);
    push_block(r, 0, 1'b0, 1'b0);
    n = 0;
    while (blk_idx < 30 && n < 2000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("reach_t30", blk_idx, 30);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    exp_q.delete();
    blk_idx = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_block(zero, 0, 1'b0, 1'b0);
    drain();

    // Back-to-back abc then all-ones, in_valid held high through EMIT with junk.
    rdy_mode = 1;
    push_block(abc, 0, 1'b0, 1'b1);
    push_block(ones, 0, 1'b1, 1'b1);
    rand_block(r);
    push_block(r, 0, 1'b1, 1'b0);
    drain();

    // A few more random blocks at full rate.
    rdy_mode = 0;
    for (int k = 0; k < 3; k++) begin
      rand_block(r);
      push_block(r, (k == 1) ? 2 : 0, 1'b0, 1'b0);
    end
    drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall cycle guard.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end
endmodule
